// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD countdown counter with ripple
// borrow, combinational borrow-out for cascading, and optional auto-reload
// of the last loaded value on underflow.
module bcd_down_counter #(
    parameter int DIGITS      = 3,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    input  logic                cin,
    output logic                bout,
    output logic                zero,
    output logic [4*DIGITS-1:0] q
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d;
    logic [W-1:0] reload_q, reload_d;
    logic [W-1:0] din_san;
    logic [W-1:0] dec_val;
    logic         run;
    logic         all_zero;

    // Clamp each preset nibble A..F down to 9 so the count path only ever sees BCD.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_san
            logic [3:0] raw;
            assign raw = din[4*i +: 4];
            assign din_san[4*i +: 4] = (raw > 4'd9) ? 4'd9 : raw;
        end
    endgenerate

    // Ripple-borrow decrement: a digit steps while every lower digit is 0.
    // Once the borrow has run through all digits, the count is all-zero.
    always_comb begin
        dec_val = q_q;
        run     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (run)
                dec_val[4*i +: 4] = (q_q[4*i +: 4] == 4'd0) ? 4'd9 : q_q[4*i +: 4] - 4'd1;
            run = run & (q_q[4*i +: 4] == 4'd0);
        end
        all_zero = run;
    end

    // Next-state select: load wins over count, count wins over hold.
    // An all-zero count naturally decrements to all-nines; auto-reload swaps that for the preset.
    always_comb begin
        q_d      = q_q;
        reload_d = reload_q;
        if (load) begin
            q_d      = din_san;
            reload_d = din_san;
        end else if (cin) begin
            q_d = (AUTO_RELOAD && all_zero) ? reload_q : dec_val;
        end
    end

    // Count and reload registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= '0;
            reload_q <= '0;
        end else begin
            q_q      <= q_d;
            reload_q <= reload_d;
        end
    end

    assign q    = q_q;
    assign zero = all_zero;
    // Borrow out stays combinational so a chain of instances settles in one cycle;
    // it is forced low while reset is held.
    assign bout = cin & ~load & ~rst & all_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed scenarios plus random
// traffic against an integer-valued reference model.
module tb_bcd_down_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, cin;
    logic [11:0] din;
    logic [11:0] q_d, q_a;
    logic        bout_d, bout_a, zero_d, zero_a;

    logic        c_load, c_cin;
    logic [11:0] c_din_lo, c_din_hi, c_q_lo, c_q_hi;
    logic        c_bout_lo, c_bout_hi, c_zero_lo, c_zero_hi;

    int errors = 0;
    int checks = 0;

    // reference model state: plain decimal integers
    int md_q, ma_q, ma_rel, mc_q;

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(3), .AUTO_RELOAD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .cin(cin),
        .bout(bout_d), .zero(zero_d), .q(q_d));

    bcd_down_counter #(.DIGITS(3), .AUTO_RELOAD(1'b1)) u_ar (
        .clk(clk), .rst(rst), .load(load), .din(din), .cin(cin),
        .bout(bout_a), .zero(zero_a), .q(q_a));

    bcd_down_counter #(.DIGITS(3), .AUTO_RELOAD(1'b0)) u_lo (
        .clk(clk), .rst(rst), .load(c_load), .din(c_din_lo), .cin(c_cin),
        .bout(c_bout_lo), .zero(c_zero_lo), .q(c_q_lo));

    bcd_down_counter #(.DIGITS(3), .AUTO_RELOAD(1'b0)) u_hi (
        .clk(clk), .rst(rst), .load(c_load), .din(c_din_hi), .cin(c_bout_lo),
        .bout(c_bout_hi), .zero(c_zero_hi), .q(c_q_hi));

    // decimal value of a 3-digit preset, A..F nibbles read as 9
    function automatic int sanit(input logic [11:0] v);
        int r = 0;
        for (int i = 2; i >= 0; i--) begin
            int n;
            n = int'(v[4*i +: 4]);
            r = r * 10 + ((n > 9) ? 9 : n);
        end
        return r;
    endfunction

    // integer -> 6-digit BCD
    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] b;
        int t;
        t = v;
        b = '0;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    // advance one clock edge and step the model with the inputs applied at that edge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            md_q = 0; ma_q = 0; ma_rel = 0; mc_q = 0;
        end else begin
            if (load) begin
                md_q = sanit(din); ma_q = md_q; ma_rel = md_q;
            end else if (cin) begin
                md_q = (md_q == 0) ? 999 : md_q - 1;
                ma_q = (ma_q == 0) ? ma_rel : ma_q - 1;
            end
            if (c_load)     mc_q = sanit(c_din_hi) * 1000 + sanit(c_din_lo);
            else if (c_cin) mc_q = (mc_q == 0) ? 999999 : mc_q - 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; cin = 1'b1; din = '0;
        c_load = 1'b0; c_cin = 1'b0; c_din_lo = '0; c_din_hi = '0;
        md_q = 0; ma_q = 0; ma_rel = 0; mc_q = 0;
        tick(); tick();
        @(negedge clk);
        checks++; if (q_d !== 12'h000) begin errors++; $display("FAIL reset_q got=%h exp=000", q_d); end
        checks++; if (zero_d !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero_d); end
        checks++; if (bout_d !== 1'b0 || bout_a !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b%b exp=00", bout_d, bout_a); end
        tick();
        rst = 1'b0;
        // load 123 then count 5 cycles, reset mid-cycle
        load = 1'b1; din = 12'h123; cin = 1'b0; tick();
        load = 1'b0; cin = 1'b1;
        repeat (5) tick();
        #2;
        checks++; if (q_d !== 12'h118) begin errors++; $display("FAIL count_before_rst got=%h exp=118", q_d); end
        rst = 1'b1;
        md_q = 0; ma_q = 0; ma_rel = 0; mc_q = 0;
        #1;
        checks++; if (q_d !== 12'h000 || q_a !== 12'h000) begin errors++; $display("FAIL async_rst_q got=%h/%h exp=000", q_d, q_a); end
        checks++; if (zero_d !== 1'b1) begin errors++; $display("FAIL async_rst_zero got=%b exp=1", zero_d); end
        checks++; if (bout_d !== 1'b0) begin errors++; $display("FAIL async_rst_bout got=%b exp=0", bout_d); end
        tick();
        rst = 1'b0;
        // after release the reload register is 0: auto-reload counter sticks at 0 and borrows
        @(negedge clk);
        checks++; if (bout_a !== 1'b1) begin errors++; $display("FAIL post_rst_bout got=%b exp=1", bout_a); end
        tick();
        @(negedge clk);
        checks++; if (q_a !== 12'h000 || bout_a !== 1'b1) begin errors++; $display("FAIL post_rst_ar got=%h/%b exp=000/1", q_a, bout_a); end
        checks++; if (q_d !== 12'h999) begin errors++; $display("FAIL post_rst_wrap got=%h exp=999", q_d); end
        cin = 1'b0;
        tick();
    endtask

    task automatic test_ripple();
        load = 1'b1; din = 12'h100; cin = 1'b0; tick();
        load = 1'b0; cin = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [23:0] e;
            e = to_bcd(100 - k);
            @(negedge clk);
            checks++; if (q_d !== e[11:0]) begin errors++; $display("FAIL ripple_q k=%0d got=%h exp=%h", k, q_d, e[11:0]); end
            checks++; if (bout_d !== 1'b0) begin errors++; $display("FAIL ripple_bout k=%0d got=%b exp=0", k, bout_d); end
            tick();
        end
        cin = 1'b0; tick();
    endtask

    task automatic test_underflow();
        int exp_v [4] = '{2, 1, 0, 999};
        load = 1'b1; din = 12'h002; cin = 1'b0; tick();
        load = 1'b0; cin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [23:0] e;
            e = to_bcd(exp_v[k]);
            @(negedge clk);
            checks++; if (q_d !== e[11:0]) begin errors++; $display("FAIL under_q k=%0d got=%h exp=%h", k, q_d, e[11:0]); end
            checks++; if (bout_d !== (k == 2)) begin errors++; $display("FAIL under_bout k=%0d got=%b exp=%b", k, bout_d, k == 2); end
            checks++; if (zero_d !== (k == 2)) begin errors++; $display("FAIL under_zero k=%0d got=%b exp=%b", k, zero_d, k == 2); end
            tick();
        end
        cin = 1'b0; tick();
    endtask

    task automatic test_auto_reload();
        int pulses = 0;
        load = 1'b1; din = 12'h005; cin = 1'b0; tick();
        load = 1'b0; cin = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [23:0] e;
            e = to_bcd(5 - (k % 6));
            @(negedge clk);
            if (bout_a === 1'b1) pulses++;
            checks++; if (q_a !== e[11:0]) begin errors++; $display("FAIL ar_q k=%0d got=%h exp=%h", k, q_a, e[11:0]); end
            checks++; if (bout_a !== (k % 6 == 5)) begin errors++; $display("FAIL ar_bout k=%0d got=%b exp=%b", k, bout_a, k % 6 == 5); end
            tick();
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL ar_pulses got=%0d exp=2", pulses); end
        cin = 1'b0; tick();
    endtask

    task automatic test_load_priority();
        load = 1'b1; cin = 1'b1; din = 12'h1F3;
        @(negedge clk);
        checks++; if (bout_d !== 1'b0 || bout_a !== 1'b0) begin errors++; $display("FAIL prio_bout got=%b%b exp=00", bout_d, bout_a); end
        tick();
        load = 1'b0; cin = 1'b0;
        @(negedge clk);
        checks++; if (q_d !== 12'h193 || q_a !== 12'h193) begin errors++; $display("FAIL prio_q got=%h/%h exp=193", q_d, q_a); end
        load = 1'b1; cin = 1'b1; din = 12'hFAB; tick();
        load = 1'b0; cin = 1'b0;
        @(negedge clk);
        checks++; if (q_d !== 12'h999) begin errors++; $display("FAIL sanit_q got=%h exp=999", q_d); end
        tick();
    endtask

    task automatic test_cascade();
        int exp_v [3] = '{1, 0, 999999};
        c_load = 1'b1; c_din_lo = 12'h001; c_din_hi = 12'h000; c_cin = 1'b1; tick();
        c_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [23:0] e;
            e = to_bcd(exp_v[k]);
            @(negedge clk);
            checks++; if ({c_q_hi, c_q_lo} !== e) begin errors++; $display("FAIL cascade_q k=%0d got=%h%h exp=%h", k, c_q_hi, c_q_lo, e); end
            checks++; if (c_bout_hi !== (k == 1)) begin errors++; $display("FAIL cascade_bout k=%0d got=%b exp=%b", k, c_bout_hi, k == 1); end
            tick();
        end
        c_cin = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [23:0] e;
            load = ($urandom_range(0, 7) == 0);
            din  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom);
            cin  = ($urandom_range(0, 3) != 0);
            c_load   = ($urandom_range(0, 15) == 0);
            c_din_lo = 12'($urandom_range(0, 2));
            c_din_hi = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
            c_cin    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e = to_bcd(md_q);
            checks++; if (q_d !== e[11:0] || zero_d !== (md_q == 0) || bout_d !== (cin && !load && md_q == 0)) begin
                errors++; $display("FAIL rand_dut k=%0d got=%h/%b/%b exp=%h/%b/%b", k, q_d, zero_d, bout_d, e[11:0], md_q == 0, cin && !load && md_q == 0);
            end
            e = to_bcd(ma_q);
            checks++; if (q_a !== e[11:0] || bout_a !== (cin && !load && ma_q == 0)) begin
                errors++; $display("FAIL rand_ar k=%0d got=%h/%b exp=%h/%b", k, q_a, bout_a, e[11:0], cin && !load && ma_q == 0);
            end
            e = to_bcd(mc_q);
            checks++; if ({c_q_hi, c_q_lo} !== e || c_bout_hi !== (c_cin && !c_load && mc_q == 0)) begin
                errors++; $display("FAIL rand_casc k=%0d got=%h%h/%b exp=%h/%b", k, c_q_hi, c_q_lo, c_bout_hi, e, c_cin && !c_load && mc_q == 0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_underflow();
        test_auto_reload();
        test_load_priority();
        test_cascade();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
